// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage registers: default payload width,
// the NOP bubble encoding and per-boundary payload widths.
package pipe_pkg;

  localparam int PIPE_DATA_W = 64;

  // RISC-V "addi x0, x0, 0", used as the bubble on instruction-carrying stages
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int FE_DEC_W  = 64;
  localparam int DEC_EX_W  = 128;
  localparam int EX_MEM_W  = 96;
  localparam int MEM_WB_W  = 64;

  localparam int SKID_MAX_COUNT   = 2;
  localparam int SINGLE_MAX_COUNT = 1;

endpackage

// File: rtl/pipe_stage_skid_reg_if.sv
// Valid/ready/data handshake bundle between two pipeline stages.
interface pipe_stage_skid_reg_if #(
  parameter int DATA_W = 64
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_entry_reg.sv
// One payload register with a valid bit; clear returns it to the bubble value
// and takes priority over load.
module pipe_entry_reg #(
  parameter int                DATA_W      = 64,
  parameter logic [DATA_W-1:0] BUBBLE_DATA = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic              valid_q,
  output logic [DATA_W-1:0] data_q
);

  logic              valid_d;
  logic [DATA_W-1:0] data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
      data_d  = BUBBLE_DATA;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= BUBBLE_DATA;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with valid/ready handshake, optional skid entry
// (registered upstream ready) and synchronous flush.
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = PIPE_DATA_W,
  parameter bit                SKID        = 1'b1,
  parameter logic [DATA_W-1:0] BUBBLE_DATA = '0
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic                          Flush,
  pipe_stage_skid_reg_if.slave          in_bus,
  pipe_stage_skid_reg_if.master         out_bus,
  output logic [1:0]                    Count
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic              main_load;
  logic              main_clear;
  logic [DATA_W-1:0] main_din;
  logic              in_fire;
  logic [1:0]        count_d;
  logic [1:0]        count_q;

  pipe_entry_reg #(
    .DATA_W      (DATA_W),
    .BUBBLE_DATA (BUBBLE_DATA)
  ) u_main (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .load    (main_load),
    .clear   (main_clear),
    .d       (main_din),
    .valid_q (main_valid),
    .data_q  (main_data)
  );

  assign in_fire       = in_bus.valid & in_bus.ready;
  assign out_bus.valid = main_valid;
  assign out_bus.data  = main_data;
  assign Count         = count_q;

  generate
    if (SKID) begin : g_skid
      logic              skid_valid;
      logic [DATA_W-1:0] skid_data;
      logic              skid_load;
      logic              skid_clear;

      pipe_entry_reg #(
        .DATA_W      (DATA_W),
        .BUBBLE_DATA (BUBBLE_DATA)
      ) u_skid (
        .clk     (Clk),
        .rst_n   (Rst_n),
        .load    (skid_load),
        .clear   (skid_clear),
        .d       (in_bus.data),
        .valid_q (skid_valid),
        .data_q  (skid_data)
      );

      // Ready depends only on a flop, so stall never ripples combinationally upstream
      assign in_bus.ready = ~skid_valid;

      always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
        main_din   = in_bus.data;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        count_d    = count_q;
        if (Flush) begin
          main_clear = 1'b1;
          skid_clear = 1'b1;
          count_d    = 2'd0;
        end else if (!main_valid || out_bus.ready) begin
          if (skid_valid) begin
            main_load = 1'b1;
            main_din  = skid_data;
            if (in_fire) begin
              skid_load = 1'b1;
              count_d   = 2'd2;
            end else begin
              skid_clear = 1'b1;
              count_d    = 2'd1;
            end
          end else if (in_fire) begin
            main_load = 1'b1;
            count_d   = 2'd1;
          end else begin
            main_clear = 1'b1;
            count_d    = 2'd0;
          end
        end else if (in_fire) begin
          skid_load = 1'b1;
          count_d   = 2'd2;
        end
      end
    end else begin : g_single
      logic out_fire;

      assign out_fire     = main_valid & out_bus.ready;
      assign in_bus.ready = out_bus.ready | ~main_valid;

      always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
        main_din   = in_bus.data;
        count_d    = count_q;
        if (Flush) begin
          main_clear = 1'b1;
          count_d    = 2'd0;
        end else if (in_fire) begin
          main_load = 1'b1;
          count_d   = 2'd1;
        end else if (out_fire) begin
          main_clear = 1'b1;
          count_d    = 2'd0;
        end
      end
    end
  endgenerate

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      count_q <= 2'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
